jk_bank_driver: RTL
===================

// Module: jk_bank_driver
// PURPOSE
//  Command-side counterpart of a JK flip-flop: converts target words into per-bit
//  J/K commands for a WIDTH-bit bank of JK flip-flops (00 hold, 01 reset, 10 set, 11 toggle).
//  Keeps a shadow copy of the bank state and reads the bank back through q_fb.
//  Re-drives mismatching bits a bounded number of times, then reports done or err.
//  Sits between a register-style host (valid/ready) and the JK flip-flop bank.
// PARAMETERS
//  WIDTH      8  number of JK flip-flops driven
//  USE_TOGGLE 0  1: changed bits driven with 11 (toggle); 0: with 10/01 (set/reset)
//  MAX_RETRY  2  extra drive attempts after a failed readback (0 = no retry)
// PORTS
//  clk       in   1      clock; all state updates on posedge
//  reset     in   1      reset, synchronous, active-high
//  in_valid  in   1      target word offered
//  in_data   in   WIDTH  target bank value
//  in_ready  out  1      block can accept a target (high only in IDLE)
//  j         out  WIDTH  J commands to the bank, registered
//  k         out  WIDTH  K commands to the bank, registered
//  q_fb      in   WIDTH  bank Q readback
//  done      out  1      1-cycle pulse: bank matches target
//  err       out  1      1-cycle pulse: retries exhausted, bank still mismatches
//  shadow_q  out  WIDTH  block's current model of the bank state
// BEHAVIOUR
//  Reset: state IDLE, j=k=0, done=err=0, shadow_q=0, retry_cnt=0, target reg=0.
//   The bank shares this reset, so the all-zero shadow is consistent with the bank.
//  States: IDLE, DRIVE, CHECK.
//  IDLE: in_ready=1; j=k=0.
//   On in_valid & in_ready, latch target=in_data and compute j/k from shadow_q.
//   Load retry_cnt=0 and go to DRIVE.
//  DRIVE: the j/k word is presented for exactly this one cycle.
//   The bank samples it at the edge that ends DRIVE.
//   Next state is CHECK, where j=k=0.
//  CHECK: compare q_fb to target.
//   Equal: done=1 for this cycle, shadow_q<=target, go to IDLE.
//   Unequal and retry_cnt<MAX_RETRY: retry_cnt++, recompute j/k from q_fb (not from
//    shadow_q), go to DRIVE.
//   Unequal and retry_cnt==MAX_RETRY: err=1 for this cycle, shadow_q<=q_fb, go to IDLE.
//  Per-bit encoding, with cur = shadow_q bit (first drive) or q_fb bit (retry):
//   tgt==cur            -> jk=00
//   tgt!=cur, USE_TOGGLE -> jk=11
//   tgt!=cur, else       -> jk = tgt ? 10 : 01
//  Latency: accept at edge T; DRIVE is the cycle after T; done/err are asserted 2 cycles
//   after accept with no retries, plus 2 cycles per retry.
//  A target equal to shadow_q still runs DRIVE (jk=00) and CHECK. It reports done, or err
//   if the bank has drifted.
//  in_valid while busy: ignored (in_ready=0); the host must hold it until accepted.
//  done and err are never high together. Neither is high outside CHECK.
//  Reset mid-operation (any state): applies all reset values at the next edge.
//   No done/err is produced for the aborted target.
//  retry_cnt width: $clog2(MAX_RETRY+1), minimum 1. It never wraps.
// STRUCTURE
//  Package jk_drv_pkg:
//   state enum {IDLE, DRIVE, CHECK};
//   JK command constants JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TGL=2'b11.
//  Sub-module jk_excite_enc: combinational per-bit encoder (cur, tgt, USE_TOGGLE) -> {j,k}.
//   Instantiated WIDTH times via generate.
//  Top level contains the FSM, the target/shadow registers, the retry counter and the
//   output registers.
// TESTING (WIDTH=8, MAX_RETRY=2; bench models an ideal JK bank unless stated)
//  1. Reset, then target 8'hA5 with USE_TOGGLE=0
//     -> DRIVE: j=8'hA5, k=8'h00; done 2 cycles after accept; shadow_q=8'hA5.
//  2. Then target 8'h5A with USE_TOGGLE=1 -> DRIVE: j=k=8'hFF; done; q_fb=8'h5A.
//  3. Target 8'h5A again -> DRIVE: j=k=8'h00; done 2 cycles after accept; no err.
//  4. Bank bit3 stuck at 0, target 8'h08 from 0
//     -> 3 DRIVE cycles, each j=8'h08; err at cycle 6 after accept; shadow_q=8'h00.
//  5. Reset asserted during DRIVE -> next cycle j=k=0, in_ready=1, shadow_q=0; no done/err.
//  6. Second in_valid held during CHECK -> in_ready=0, target not taken; accepted the cycle
//     after done; its j/k are computed from the updated shadow_q.

Source files
------------

// File: rtl/jk_drv_pkg.sv
// Shared types and JK command encodings for the JK bank driver.
package jk_drv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK
  } state_e;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Retry counter must hold 0..max_retry and never be narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_retry);
    int unsigned w;
    w = $clog2(max_retry + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/jk_excite_enc.sv
// Per-bit JK excitation encoder: picks the command that moves cur to tgt.
module jk_excite_enc
  import jk_drv_pkg::*;
#(
  parameter bit USE_TOGGLE = 1'b0
) (
  input  logic       i_cur,
  input  logic       i_tgt,
  output logic [1:0] o_jk
);

  always_comb begin
    o_jk = JK_HOLD;
    if (i_cur != i_tgt) begin
      if (USE_TOGGLE) begin
        o_jk = JK_TGL;
      end else begin
        o_jk = i_tgt ? JK_SET : JK_RST;
      end
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Converts host target words into J/K commands for a JK flip-flop bank,
// verifies the readback and re-drives mismatching bits a bounded number of times.
module jk_bank_driver
  import jk_drv_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          USE_TOGGLE = 1'b0,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] shadow_q
);

  localparam int unsigned      RW        = cnt_width(MAX_RETRY);
  localparam logic [RW-1:0]    MaxRetryW = RW'(MAX_RETRY);

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_target, w_target_d;
  logic [WIDTH-1:0] r_shadow, w_shadow_d;
  logic [RW-1:0]    r_retry, w_retry_d;
  logic [WIDTH-1:0] r_j, w_j_d;
  logic [WIDTH-1:0] r_k, w_k_d;

  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_tgt;
  logic [WIDTH-1:0] w_enc_j;
  logic [WIDTH-1:0] w_enc_k;
  logic             w_match;

  // First drive works from the shadow; retries work from what the bank actually holds.
  assign w_cur   = (r_state == CHECK) ? q_fb : r_shadow;
  assign w_tgt   = (r_state == IDLE) ? in_data : r_target;
  assign w_match = (q_fb == r_target);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_enc
    logic [1:0] w_jk;

    jk_excite_enc #(
      .USE_TOGGLE(USE_TOGGLE)
    ) u_enc (
      .i_cur(w_cur[gi]),
      .i_tgt(w_tgt[gi]),
      .o_jk (w_jk)
    );

    assign w_enc_j[gi] = w_jk[1];
    assign w_enc_k[gi] = w_jk[0];
  end

  always_comb begin
    w_state_d  = r_state;
    w_target_d = r_target;
    w_shadow_d = r_shadow;
    w_retry_d  = r_retry;
    w_j_d      = '0;
    w_k_d      = '0;
    in_ready   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_target_d = in_data;
          w_j_d      = w_enc_j;
          w_k_d      = w_enc_k;
          w_retry_d  = '0;
          w_state_d  = DRIVE;
        end
      end
      DRIVE: begin
        w_state_d = CHECK;
      end
      CHECK: begin
        // A reset landing on CHECK aborts the target silently.
        if (w_match) begin
          done       = ~reset;
          w_shadow_d = r_target;
          w_state_d  = IDLE;
        end else if (r_retry < MaxRetryW) begin
          w_retry_d = r_retry + RW'(1);
          w_j_d     = w_enc_j;
          w_k_d     = w_enc_k;
          w_state_d = DRIVE;
        end else begin
          err        = ~reset;
          w_shadow_d = q_fb;
          w_state_d  = IDLE;
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_target <= '0;
      r_shadow <= '0;
      r_retry  <= '0;
      r_j      <= '0;
      r_k      <= '0;
    end else begin
      r_state  <= w_state_d;
      r_target <= w_target_d;
      r_shadow <= w_shadow_d;
      r_retry  <= w_retry_d;
      r_j      <= w_j_d;
      r_k      <= w_k_d;
    end
  end

  assign j        = r_j;
  assign k        = r_k;
  assign shadow_q = r_shadow;

endmodule
